// File: rtl/keyboard_matrix.sv
// PS/2 set-2 key events mapped onto a 10x8 PC-8001 style key matrix.
// Each release is held back until a press has stayed visible for HOLD_CYCLES.
module keyboard_matrix #(
  parameter logic [19:0] HOLD_CYCLES = 20'd1000000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [3:0]  row_sel,
  output logic [7:0]  row_data,
  output logic        key_stop,
  output logic        any_key
);

  logic        r_toggle;
  logic [79:0] r_matrix;
  logic [19:0] r_hold_cnt;
  logic [6:0]  r_fifo_idx [4];
  logic [3:0]  r_fifo_vld;
  logic [1:0]  r_rd_ptr;
  logic [1:0]  r_wr_ptr;
  logic [2:0]  r_fifo_cnt;
  logic [7:0]  r_row_data;
  logic        r_key_stop;
  logic        r_any_key;

  logic [7:0]  w_map;
  logic        w_map_hit;
  logic [6:0]  w_idx;
  logic        w_event;
  logic        w_press;
  logic        w_release;
  logic        w_cnt_zero;
  logic        w_fifo_empty;
  logic        w_fifo_full;
  logic        w_pop;
  logic        w_push;
  logic        w_rel_clear;
  logic [79:0] w_matrix_nxt;
  logic [3:0]  w_vld_nxt;
  logic [7:0]  w_row_bits;

  // Decode {E0, scancode} to {hit, row, col}; the bit index is simply {row, col}.
  always_comb begin
    w_map = 8'h00;
    case ({ps2_key[8], ps2_key[7:0]})
      9'h070: w_map = {1'b1, 4'd0, 3'd0};
      9'h069: w_map = {1'b1, 4'd0, 3'd1};
      9'h072: w_map = {1'b1, 4'd0, 3'd2};
      9'h07A: w_map = {1'b1, 4'd0, 3'd3};
      9'h06B: w_map = {1'b1, 4'd0, 3'd4};
      9'h073: w_map = {1'b1, 4'd0, 3'd5};
      9'h074: w_map = {1'b1, 4'd0, 3'd6};
      9'h06C: w_map = {1'b1, 4'd0, 3'd7};
      9'h075: w_map = {1'b1, 4'd1, 3'd0};
      9'h07D: w_map = {1'b1, 4'd1, 3'd1};
      9'h07C: w_map = {1'b1, 4'd1, 3'd2};
      9'h079: w_map = {1'b1, 4'd1, 3'd3};
      9'h071: w_map = {1'b1, 4'd1, 3'd6};
      9'h05A: w_map = {1'b1, 4'd1, 3'd7};
      9'h15A: w_map = {1'b1, 4'd1, 3'd7};
      9'h054: w_map = {1'b1, 4'd2, 3'd0};
      9'h01C: w_map = {1'b1, 4'd2, 3'd1};
      9'h032: w_map = {1'b1, 4'd2, 3'd2};
      9'h021: w_map = {1'b1, 4'd2, 3'd3};
      9'h023: w_map = {1'b1, 4'd2, 3'd4};
      9'h024: w_map = {1'b1, 4'd2, 3'd5};
      9'h02B: w_map = {1'b1, 4'd2, 3'd6};
      9'h034: w_map = {1'b1, 4'd2, 3'd7};
      9'h033: w_map = {1'b1, 4'd3, 3'd0};
      9'h043: w_map = {1'b1, 4'd3, 3'd1};
      9'h03B: w_map = {1'b1, 4'd3, 3'd2};
      9'h042: w_map = {1'b1, 4'd3, 3'd3};
      9'h04B: w_map = {1'b1, 4'd3, 3'd4};
      9'h03A: w_map = {1'b1, 4'd3, 3'd5};
      9'h031: w_map = {1'b1, 4'd3, 3'd6};
      9'h044: w_map = {1'b1, 4'd3, 3'd7};
      9'h04D: w_map = {1'b1, 4'd4, 3'd0};
      9'h015: w_map = {1'b1, 4'd4, 3'd1};
      9'h02D: w_map = {1'b1, 4'd4, 3'd2};
      9'h01B: w_map = {1'b1, 4'd4, 3'd3};
      9'h02C: w_map = {1'b1, 4'd4, 3'd4};
      9'h03C: w_map = {1'b1, 4'd4, 3'd5};
      9'h02A: w_map = {1'b1, 4'd4, 3'd6};
      9'h01D: w_map = {1'b1, 4'd4, 3'd7};
      9'h022: w_map = {1'b1, 4'd5, 3'd0};
      9'h035: w_map = {1'b1, 4'd5, 3'd1};
      9'h01A: w_map = {1'b1, 4'd5, 3'd2};
      9'h05B: w_map = {1'b1, 4'd5, 3'd3};
      9'h061: w_map = {1'b1, 4'd5, 3'd4};
      9'h05D: w_map = {1'b1, 4'd5, 3'd5};
      9'h055: w_map = {1'b1, 4'd5, 3'd6};
      9'h04E: w_map = {1'b1, 4'd5, 3'd7};
      9'h045: w_map = {1'b1, 4'd6, 3'd0};
      9'h016: w_map = {1'b1, 4'd6, 3'd1};
      9'h01E: w_map = {1'b1, 4'd6, 3'd2};
      9'h026: w_map = {1'b1, 4'd6, 3'd3};
      9'h025: w_map = {1'b1, 4'd6, 3'd4};
      9'h02E: w_map = {1'b1, 4'd6, 3'd5};
      9'h036: w_map = {1'b1, 4'd6, 3'd6};
      9'h03D: w_map = {1'b1, 4'd6, 3'd7};
      9'h03E: w_map = {1'b1, 4'd7, 3'd0};
      9'h046: w_map = {1'b1, 4'd7, 3'd1};
      9'h052: w_map = {1'b1, 4'd7, 3'd2};
      9'h04C: w_map = {1'b1, 4'd7, 3'd3};
      9'h041: w_map = {1'b1, 4'd7, 3'd4};
      9'h049: w_map = {1'b1, 4'd7, 3'd5};
      9'h04A: w_map = {1'b1, 4'd7, 3'd6};
      9'h00E: w_map = {1'b1, 4'd7, 3'd7};
      9'h16C: w_map = {1'b1, 4'd8, 3'd0};
      9'h175: w_map = {1'b1, 4'd8, 3'd1};
      9'h174: w_map = {1'b1, 4'd8, 3'd2};
      9'h066: w_map = {1'b1, 4'd8, 3'd3};
      9'h171: w_map = {1'b1, 4'd8, 3'd3};
      9'h011: w_map = {1'b1, 4'd8, 3'd4};
      9'h111: w_map = {1'b1, 4'd8, 3'd5};
      9'h012: w_map = {1'b1, 4'd8, 3'd6};
      9'h059: w_map = {1'b1, 4'd8, 3'd6};
      9'h014: w_map = {1'b1, 4'd8, 3'd7};
      9'h169: w_map = {1'b1, 4'd9, 3'd0};
      9'h005: w_map = {1'b1, 4'd9, 3'd1};
      9'h006: w_map = {1'b1, 4'd9, 3'd2};
      9'h004: w_map = {1'b1, 4'd9, 3'd3};
      9'h00C: w_map = {1'b1, 4'd9, 3'd4};
      9'h003: w_map = {1'b1, 4'd9, 3'd5};
      9'h029: w_map = {1'b1, 4'd9, 3'd6};
      9'h076: w_map = {1'b1, 4'd9, 3'd7};
      default: w_map = 8'h00;
    endcase
  end

  assign w_map_hit    = w_map[7];
  assign w_idx        = w_map[6:0];
  assign w_event      = ps2_key[10] ^ r_toggle;
  assign w_press      = w_event & w_map_hit & ps2_key[9];
  assign w_release    = w_event & w_map_hit & ~ps2_key[9];
  assign w_cnt_zero   = (r_hold_cnt == 20'd0);
  assign w_fifo_empty = (r_fifo_cnt == 3'd0);
  assign w_fifo_full  = (r_fifo_cnt == 3'd4);
  assign w_pop        = w_cnt_zero & ~w_fifo_empty;
  assign w_rel_clear  = w_release & ((w_cnt_zero & w_fifo_empty) | w_fifo_full);
  assign w_push       = w_release & ~w_rel_clear;

  // Press is applied last so it overrides a same-cycle pop of the same bit.
  always_comb begin
    w_matrix_nxt = r_matrix;
    if (w_pop && r_fifo_vld[r_rd_ptr]) w_matrix_nxt[r_fifo_idx[r_rd_ptr]] = 1'b0;
    if (w_rel_clear) w_matrix_nxt[w_idx] = 1'b0;
    if (w_press) w_matrix_nxt[w_idx] = 1'b1;
  end

  always_comb begin
    w_vld_nxt = r_fifo_vld;
    if (w_pop) w_vld_nxt[r_rd_ptr] = 1'b0;
    if (w_push) w_vld_nxt[r_wr_ptr] = 1'b1;
    if (w_press) begin
      for (int i = 0; i < 4; i++) begin
        if (r_fifo_idx[i] == w_idx) w_vld_nxt[i] = 1'b0;
      end
    end
  end

  assign w_row_bits = (row_sel <= 4'd9) ? r_matrix[{row_sel, 3'b000} +: 8] : 8'h00;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_toggle   <= ps2_key[10];
      r_matrix   <= '0;
      r_hold_cnt <= '0;
      r_fifo_vld <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_fifo_cnt <= '0;
      r_row_data <= 8'hFF;
      r_key_stop <= 1'b0;
      r_any_key  <= 1'b0;
      for (int i = 0; i < 4; i++) r_fifo_idx[i] <= '0;
    end else begin
      r_toggle   <= ps2_key[10];
      r_matrix   <= w_matrix_nxt;
      r_fifo_vld <= w_vld_nxt;
      if (w_press) r_hold_cnt <= HOLD_CYCLES;
      else if (!w_cnt_zero) r_hold_cnt <= r_hold_cnt - 20'd1;
      if (w_push) begin
        r_fifo_idx[r_wr_ptr] <= w_idx;
        r_wr_ptr <= r_wr_ptr + 2'd1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 2'd1;
      r_fifo_cnt <= r_fifo_cnt + {2'b00, w_push} - {2'b00, w_pop};
      r_row_data <= (row_sel <= 4'd9) ? ~w_row_bits : 8'hFF;
      r_key_stop <= r_matrix[72];
      r_any_key  <= |r_matrix;
    end
  end

  assign row_data = r_row_data;
  assign key_stop = r_key_stop;
  assign any_key  = r_any_key;

endmodule

// File: tb/tb_keyboard_matrix.sv
// Directed and randomized key traffic for keyboard_matrix, checked every cycle
// against a queue-based model of the matrix and the delayed-release list.
module tb_keyboard_matrix;

  localparam int HOLD = 100;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic [3:0]  row_sel;
  logic [7:0]  row_data;
  logic        key_stop;
  logic        any_key;

  keyboard_matrix #(.HOLD_CYCLES(20'd100)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .ps2_key (ps2_key),
    .row_sel (row_sel),
    .row_data(row_data),
    .key_stop(key_stop),
    .any_key (any_key)
  );

  always #5 clk_sys = ~clk_sys;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int idx;
    bit vld;
  } rel_t;

  bit [79:0] m;
  int        cnt;
  rel_t      q[$];
  bit        prev_tgl;
  logic [7:0] e_row;
  logic       e_stop;
  logic       e_any;

  logic [8:0] kc [19] = '{9'h01C, 9'h032, 9'h021, 9'h023, 9'h024, 9'h05A, 9'h15A,
                          9'h012, 9'h059, 9'h029, 9'h076, 9'h005, 9'h169, 9'h069,
                          9'h01A, 9'h016, 9'h175, 9'h066, 9'h171};
  int         ki [19] = '{17, 18, 19, 20, 21, 15, 15, 70, 70, 78, 79, 73, 72, 1,
                          42, 49, 65, 67, 67};
  logic [8:0] uc [6]  = '{9'h000, 9'h0FF, 9'h07E, 9'h077, 9'h11C, 9'h1AA};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int lookup(input logic [8:0] code);
    for (int i = 0; i < 19; i++) if (kc[i] == code) return ki[i];
    return -1;
  endfunction

  task automatic model_step();
    bit ev;
    int idx;
    bit zero;
    int sz0;
    bit pressed;
    rel_t e;
    if (reset) begin
      m = '0;
      cnt = 0;
      q.delete();
      prev_tgl = ps2_key[10];
      e_row = 8'hFF;
      e_stop = 1'b0;
      e_any = 1'b0;
    end else begin
      e_row = 8'hFF;
      if (row_sel < 10)
        for (int c = 0; c < 8; c++) e_row[c] = ~m[int'(row_sel) * 8 + c];
      e_stop = m[9 * 8 + 0];
      e_any  = (m != '0);
      ev = (ps2_key[10] != prev_tgl);
      prev_tgl = ps2_key[10];
      idx = lookup(ps2_key[8:0]);
      zero = (cnt == 0);
      sz0 = q.size();
      pressed = 1'b0;
      if (zero && sz0 > 0) begin
        e = q.pop_front();
        if (e.vld) m[e.idx] = 1'b0;
      end
      if (ev && idx >= 0) begin
        if (ps2_key[9]) begin
          for (int i = 0; i < q.size(); i++) begin
            e = q[i];
            if (e.idx == idx) e.vld = 1'b0;
            q[i] = e;
          end
          m[idx] = 1'b1;
          cnt = HOLD;
          pressed = 1'b1;
        end else if ((zero && sz0 == 0) || sz0 == 4) begin
          m[idx] = 1'b0;
        end else begin
          e.idx = idx;
          e.vld = 1'b1;
          q.push_back(e);
        end
      end
      if (!pressed && cnt > 0) cnt--;
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    model_step();
    @(negedge clk_sys);
    chk("row_data", {24'h0, row_data}, {24'h0, e_row});
    chk("key_stop", {31'h0, key_stop}, {31'h0, e_stop});
    chk("any_key", {31'h0, any_key}, {31'h0, e_any});
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic ev(input bit p, input logic [8:0] code);
    ps2_key = {~ps2_key[10], p, code};
    tick();
  endtask

  initial begin
    int r;
    reset = 1'b1;
    ps2_key = 11'h000;
    row_sel = 4'd2;
    idle(3);
    chk("reset_row", {24'h0, row_data}, 32'hFF);
    chk("reset_any", {31'h0, any_key}, 32'h0);
    reset = 1'b0;
    idle(2);

    // press A, visible two cycles after the toggle
    ev(1'b1, 9'h01C);
    tick();
    chk("press_a_row", {24'h0, row_data}, 32'hFD);
    chk("press_a_any", {31'h0, any_key}, 32'h1);

    // release queued behind the hold counter
    idle(8);
    ev(1'b0, 9'h01C);
    idle(80);
    chk("hold_row", {24'h0, row_data}, 32'hFD);
    idle(20);
    chk("hold_expired_row", {24'h0, row_data}, 32'hFF);

    // five releases: the fifth overflows and clears at once
    ev(1'b1, 9'h01C); ev(1'b1, 9'h032); ev(1'b1, 9'h021); ev(1'b1, 9'h023); ev(1'b1, 9'h024);
    idle(3);
    ev(1'b0, 9'h01C); ev(1'b0, 9'h032); ev(1'b0, 9'h021); ev(1'b0, 9'h023); ev(1'b0, 9'h024);
    tick();
    chk("overflow_row", {24'h0, row_data}, 32'hE1);
    idle(120);
    chk("drain_row", {24'h0, row_data}, 32'hFF);

    // re-press cancels the stale queued release
    ev(1'b1, 9'h01C);
    ev(1'b0, 9'h01C);
    ev(1'b1, 9'h01C);
    idle(150);
    chk("repress_row", {24'h0, row_data}, 32'hFD);
    ev(1'b0, 9'h01C);
    idle(3);
    chk("repress_release_row", {24'h0, row_data}, 32'hFF);

    // STOP, an unmapped code, and a long quiet stretch
    row_sel = 4'd9;
    ev(1'b1, 9'h169);
    tick();
    chk("stop_key", {31'h0, key_stop}, 32'h1);
    chk("stop_row", {24'h0, row_data}, 32'hFE);
    ev(1'b1, 9'h000);
    idle(100);
    chk("unmapped_row", {24'h0, row_data}, 32'hFE);
    ev(1'b0, 9'h169);
    idle(3);
    chk("stop_release", {31'h0, key_stop}, 32'h0);

    // reset with two queued releases and three keys down
    row_sel = 4'd2;
    ev(1'b1, 9'h01C); ev(1'b1, 9'h032); ev(1'b1, 9'h029);
    ev(1'b0, 9'h01C); ev(1'b0, 9'h032);
    reset = 1'b1;
    ps2_key = {~ps2_key[10], 1'b1, 9'h021};
    tick();
    reset = 1'b0;
    chk("rst_mid_row", {24'h0, row_data}, 32'hFF);
    chk("rst_mid_stop", {31'h0, key_stop}, 32'h0);
    chk("rst_mid_any", {31'h0, any_key}, 32'h0);
    idle(5);
    chk("rst_no_event", {31'h0, any_key}, 32'h0);
    ev(1'b1, 9'h021);
    tick();
    chk("post_rst_row", {24'h0, row_data}, 32'hF7);
    idle(150);
    chk("post_rst_hold", {24'h0, row_data}, 32'hF7);
    ev(1'b0, 9'h021);
    idle(3);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      row_sel = 4'($urandom_range(0, 15));
      if (r < 4) begin
        reset = 1'b1;
        if ($urandom_range(0, 1) == 1) ps2_key[10] = ~ps2_key[10];
        idle($urandom_range(1, 2));
        reset = 1'b0;
      end else if (r < 14) begin
        ev(1'($urandom_range(0, 1)), uc[$urandom_range(0, 5)]);
      end else if (r < 20) begin
        ps2_key[9:0] = 10'($urandom);
        tick();
      end else begin
        ev(($urandom_range(0, 9) < 6), kc[$urandom_range(0, 18)]);
      end
      if ($urandom_range(0, 4) == 0) begin
        for (int k = $urandom_range(60, 130); k > 0; k--) begin
          row_sel = 4'($urandom_range(0, 15));
          tick();
        end
      end else begin
        for (int k = $urandom_range(0, 3); k > 0; k--) begin
          row_sel = 4'($urandom_range(0, 15));
          tick();
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keyboard_matrix.md
KEYBOARD_MATRIX -- requirements
Module: keyboard_matrix

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 20'd1000000, giving the minimum press-to-release visibility in clk_sys cycles.
REQ-002 SHALL have port clk_sys  in  1  system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset  in  1  synchronous reset, active-high.
REQ-004 SHALL have port ps2_key  in  11  key event from hps_io: [10] toggles once per event, [9] 1 = press, [8] E0-extended, [7:0] set-2 scancode.
REQ-005 SHALL have port row_sel  in  4  keyboard port address low nibble (rows 0-9).
REQ-006 SHALL have port row_data  out  8  selected row, active-low (0 = key down).
REQ-007 SHALL have port key_stop  out  1  high while the STOP key is down.
REQ-008 SHALL have port any_key  out  1  high while any matrix bit is down.

Function
REQ-009 SHALL hold an 80-bit matrix, 10 rows x 8 columns, with bit = 1 meaning down.
REQ-010 SHALL register the previous ps2_key[10]; an event is detected when ps2_key[10] differs from the registered value, one event per toggle.
REQ-011 SHALL decode {ext, scancode} to (row, col) with a combinational table; unmapped codes SHALL be ignored with no state change.
REQ-012 SHALL implement the mandatory mappings below; remaining keys follow the PC-8001 layout:
- A (1C) -> row 2 col 1
- RETURN (5A, E0 5A) -> row 1 col 7
- L/R SHIFT (12/59) -> row 8 col 6
- SPACE (29) -> row 9 col 6
- ESC (76) -> row 9 col 7
- F1 (05) -> row 9 col 1
- STOP (E0 69, End) -> row 9 col 0
REQ-013 A press event SHALL set the mapped bit in the cycle after detection and SHALL reload the hold counter with HOLD_CYCLES.
REQ-014 The hold counter SHALL be 20 bits, decrement by 1 each cycle while nonzero, and saturate at 0.
REQ-015 A release event SHALL be handled as follows:
- counter = 0 and FIFO empty: clear the bit the next cycle.
- otherwise: push (row, col) into a 4-entry release FIFO.
- FIFO full: clear the bit immediately; no push.
REQ-016 While counter = 0, the FIFO SHALL pop one valid entry per cycle, clearing its bit; invalid entries SHALL pop with no effect.
REQ-017 A press of a key SHALL clear the valid flag of every FIFO entry with the same (row, col) in the same cycle, so the stale release is cancelled.
REQ-018 Keys mapping to the same bit (L/R SHIFT) SHALL share that bit; releasing either SHALL release it.
REQ-019 If a press event and a FIFO pop target the same bit in the same cycle, the press SHALL win (bit = 1).
REQ-020 row_data SHALL be registered as ~matrix[row_sel], with 1-cycle latency from row_sel; row_sel 10-15 SHALL return 8'hFF.
REQ-021 key_stop and any_key SHALL be registered from the matrix, with 1-cycle latency after a matrix change.

Reset
REQ-022 During reset the following SHALL hold:
- matrix = 0 and row_data = 8'hFF
- key_stop = 0 and any_key = 0
- hold counter = 0
- FIFO empty, all valid flags cleared
- the toggle register loads the current ps2_key[10], so no event is generated on reset release
REQ-023 Reset asserted mid-hold or with the FIFO non-empty SHALL discard all pending releases.

Verification
REQ-024 Press A (ps2_key = 11'h61C, toggle) with row_sel = 2 -> row_data = 8'hFD two cycles after the toggle; any_key = 1.
REQ-025 Press A, then release A (11'h01C) 10 cycles later with HOLD_CYCLES = 100 -> row_data stays 8'hFD until counter = 0, then 8'hFF within 2 cycles.
REQ-026 Five releases queued during hold (keys A-E pressed, then released) -> the fifth clears immediately, and the remaining four clear on consecutive cycles after counter = 0.
REQ-027 Press A, release A (queued), press A again before expiry -> row_data = 8'hFD persists after the counter expires.
REQ-028 Press E0 69 -> key_stop = 1 and row 9 = 8'hFE; unmapped code 11'h600 toggled -> no matrix change; ps2_key[10] unchanged for 100 cycles -> no event.
REQ-029 Assert reset with the FIFO holding 2 entries and 3 keys down -> next cycle all rows read 8'hFF, key_stop = 0, and the first post-reset toggle is the only event detected.
